// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - down-counting H:M:S timer with load, start/pause and sticky expiry
module countdown_timer #(
    parameter int HOUR_MAX = 23
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TICK,
    input  logic       LOAD,
    input  logic [5:0] Load_Hours,
    input  logic [5:0] Load_Mins,
    input  logic [5:0] Load_Secs,
    input  logic       START,
    input  logic       PAUSE,
    output logic [5:0] Hours,
    output logic [5:0] Mins,
    output logic [5:0] Secs,
    output logic       Running,
    output logic       Done,
    output logic       Expired,
    output logic       Load_Err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [5:0] HMAX = 6'(HOUR_MAX);

    state_t     state;
    logic       load_ok;
    logic       count_zero;
    logic [5:0] dec_hours;
    logic [5:0] dec_mins;
    logic [5:0] dec_secs;
    logic       dec_zero;

    assign load_ok    = (Load_Hours <= HMAX) && (Load_Mins <= 6'd59) && (Load_Secs <= 6'd59);
    assign count_zero = (Hours == 6'd0) && (Mins == 6'd0) && (Secs == 6'd0);

    // Borrow chain; only consulted in RUN, where the count is never zero.
    always_comb begin
        dec_hours = Hours;
        dec_mins  = Mins;
        dec_secs  = Secs;
        if (Secs != 6'd0) begin
            dec_secs = Secs - 6'd1;
        end else if (Mins != 6'd0) begin
            dec_secs = 6'd59;
            dec_mins = Mins - 6'd1;
        end else if (Hours != 6'd0) begin
            dec_secs  = 6'd59;
            dec_mins  = 6'd59;
            dec_hours = Hours - 6'd1;
        end
        dec_zero = (dec_hours == 6'd0) && (dec_mins == 6'd0) && (dec_secs == 6'd0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            Hours    <= 6'd0;
            Mins     <= 6'd0;
            Secs     <= 6'd0;
            Running  <= 1'b0;
            Done     <= 1'b0;
            Expired  <= 1'b0;
            Load_Err <= 1'b0;
        end else begin
            Done     <= 1'b0;
            Load_Err <= 1'b0;
            if (LOAD) begin
                if (load_ok) begin
                    Hours   <= Load_Hours;
                    Mins    <= Load_Mins;
                    Secs    <= Load_Secs;
                    state   <= IDLE;
                    Running <= 1'b0;
                    Expired <= 1'b0;
                end else begin
                    Load_Err <= 1'b1;
                end
            end else if (START) begin
                if ((state == IDLE || state == PAUSED) && !count_zero) begin
                    state   <= RUN;
                    Running <= 1'b1;
                end
            end else if (PAUSE) begin
                if (state == RUN) begin
                    state   <= PAUSED;
                    Running <= 1'b0;
                end
            end else if (TICK && state == RUN) begin
                Hours <= dec_hours;
                Mins  <= dec_mins;
                Secs  <= dec_secs;
                if (dec_zero) begin
                    state   <= EXPIRED;
                    Running <= 1'b0;
                    Done    <= 1'b1;
                    Expired <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed vector bench for countdown_timer
module tb_countdown_timer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       TICK, LOAD, START, PAUSE;
    logic [5:0] Load_Hours, Load_Mins, Load_Secs;
    logic [5:0] Hours, Mins, Secs;
    logic       Running, Done, Expired, Load_Err;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.HOUR_MAX(23)) dut (
        .CLK(CLK), .RST_N(RST_N), .TICK(TICK), .LOAD(LOAD),
        .Load_Hours(Load_Hours), .Load_Mins(Load_Mins), .Load_Secs(Load_Secs),
        .START(START), .PAUSE(PAUSE),
        .Hours(Hours), .Mins(Mins), .Secs(Secs),
        .Running(Running), .Done(Done), .Expired(Expired), .Load_Err(Load_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ld;
        logic [5:0] lh, lm, ls;
        logic       st, pa, tk;
        logic [5:0] eh, em, es;
        logic       erun, edone, eexp, eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld, input logic [5:0] lh, input logic [5:0] lm,
                       input logic [5:0] ls, input logic st, input logic pa, input logic tk,
                       input logic [5:0] eh, input logic [5:0] em, input logic [5:0] es,
                       input logic erun, input logic edone, input logic eexp, input logic eerr);
        vec_t v;
        v.ld = ld; v.lh = lh; v.lm = lm; v.ls = ls;
        v.st = st; v.pa = pa; v.tk = tk;
        v.eh = eh; v.em = em; v.es = es;
        v.erun = erun; v.edone = edone; v.eexp = eexp; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [5:0] eh, input logic [5:0] em,
                         input logic [5:0] es, input logic erun, input logic edone,
                         input logic eexp, input logic eerr);
        checks++;
        if (Hours !== eh || Mins !== em || Secs !== es || Running !== erun ||
            Done !== edone || Expired !== eexp || Load_Err !== eerr) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d run=%b done=%b exp=%b err=%b, want %0d:%0d:%0d run=%b done=%b exp=%b err=%b",
                     name, Hours, Mins, Secs, Running, Done, Expired, Load_Err,
                     eh, em, es, erun, edone, eexp, eerr);
        end
    endtask

    task automatic drive(input logic ld, input logic [5:0] lh, input logic [5:0] lm,
                         input logic [5:0] ls, input logic st, input logic pa, input logic tk);
        LOAD = ld; Load_Hours = lh; Load_Mins = lm; Load_Secs = ls;
        START = st; PAUSE = pa; TICK = tk;
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        //   ld lh  lm  ls st pa tk   eh  em  es run dn ex er
        // Plan 1: 0:0:3 countdown with TICK held high
        add(1, 0,  0,  3, 0, 0, 1,   0,  0,  3, 0, 0, 0, 0);
        add(0, 0,  0,  0, 1, 0, 1,   0,  0,  3, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  2, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  1, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  0, 0, 1, 1, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  0, 0, 0, 1, 0);
        // Plan 2: hour borrow, illegal loads, largest legal load
        add(1, 1,  0,  0, 0, 0, 0,   1,  0,  0, 0, 0, 0, 0);
        add(0, 0,  0,  0, 1, 0, 0,   1,  0,  0, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0, 59, 59, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 0,   0, 59, 59, 1, 0, 0, 0);
        add(1, 0, 60,  0, 0, 0, 0,   0, 59, 59, 1, 0, 0, 1);
        add(0, 0,  0,  0, 0, 0, 0,   0, 59, 59, 1, 0, 0, 0);
        add(1, 24, 0,  0, 0, 0, 0,   0, 59, 59, 1, 0, 0, 1);
        add(1, 0,  0, 60, 0, 0, 1,   0, 59, 59, 1, 0, 0, 1);
        add(1, 23, 59, 59, 0, 0, 0, 23, 59, 59, 0, 0, 0, 0);
        // Plan 3: pause and resume
        add(1, 0,  0,  5, 0, 0, 0,   0,  0,  5, 0, 0, 0, 0);
        add(0, 0,  0,  0, 1, 0, 0,   0,  0,  5, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  4, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  3, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 1, 0,   0,  0,  3, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0);
        add(0, 0,  0,  0, 1, 0, 0,   0,  0,  3, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  2, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  1, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  0, 0, 1, 1, 0);
        // Plan 4: LOAD beats START and TICK while running
        add(1, 0,  0,  6, 0, 0, 0,   0,  0,  6, 0, 0, 0, 0);
        add(0, 0,  0,  0, 1, 0, 0,   0,  0,  6, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  5, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  4, 1, 0, 0, 0);
        add(1, 0,  0,  9, 1, 0, 1,   0,  0,  9, 0, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  9, 0, 0, 0, 0);
        // Plan 5: zero load cannot start; expired state is sticky
        add(1, 0,  0,  0, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0);
        add(0, 0,  0,  0, 1, 0, 0,   0,  0,  0, 0, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  0, 0, 0, 0, 0);
        add(1, 0,  0,  1, 0, 0, 0,   0,  0,  1, 0, 0, 0, 0);
        add(0, 0,  0,  0, 1, 0, 0,   0,  0,  1, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  0, 0, 1, 1, 0);
        add(0, 0,  0,  0, 1, 0, 0,   0,  0,  0, 0, 0, 1, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  0,  0, 0, 0, 1, 0);
        add(0, 0,  0,  0, 0, 1, 0,   0,  0,  0, 0, 0, 1, 0);
        add(1, 0,  0, 63, 0, 0, 0,   0,  0,  0, 0, 0, 1, 1);
        add(1, 0,  0,  2, 0, 0, 0,   0,  0,  2, 0, 0, 0, 0);
        // Minute borrow
        add(1, 0,  2,  0, 0, 0, 0,   0,  2,  0, 0, 0, 0, 0);
        add(0, 0,  0,  0, 1, 0, 0,   0,  2,  0, 1, 0, 0, 0);
        add(0, 0,  0,  0, 0, 0, 1,   0,  1, 59, 1, 0, 0, 0);

        #12;
        check("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        cycle();

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lh, vecs[i].lm, vecs[i].ls, vecs[i].st, vecs[i].pa, vecs[i].tk);
            cycle();
            check($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es,
                  vecs[i].erun, vecs[i].edone, vecs[i].eexp, vecs[i].eerr);
        end

        // Plan 6: asynchronous reset mid-run at 0:30:10
        drive(1, 0, 30, 12, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0, 0);   cycle();
        drive(0, 0, 0, 0, 0, 0, 1);   cycle();
        cycle();
        check("prereset", 0, 30, 10, 1, 0, 0, 0);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check($sformatf("rst_hold%0d", i), 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("post_rst_tick%0d", i), 0, 0, 0, 0, 0, 0, 0);
        end
        drive(1, 0, 0, 2, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 1); cycle();
        check("restart", 0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting H:M:S timer; mirror of the up-counting calendar time base.
- Software/front panel loads a duration, starts it, and the block decrements once per qualified tick down to 00:00:00, then flags expiry.
- Outputs use the same 6-bit Hours/Mins/Secs encoding as the calendar, so the display path and any comparators are shared.

Parameters:
- HOUR_MAX, 23, largest legal loadable hour value; must be ≤ 63.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- TICK  in  1  one-cycle count enable (1 Hz strobe in system; tie high for per-clock counting).
- LOAD  in  1  load request; one-cycle pulse.
- Load_Hours  in  6  duration hours, sampled on LOAD.
- Load_Mins  in  6  duration minutes, sampled on LOAD.
- Load_Secs  in  6  duration seconds, sampled on LOAD.
- START  in  1  start/resume request; one-cycle pulse.
- PAUSE  in  1  pause request; one-cycle pulse.
- Hours  out  6  remaining hours.
- Mins  out  6  remaining minutes.
- Secs  out  6  remaining seconds.
- Running  out  1  high while in RUN.
- Done  out  1  one-cycle pulse when count reaches zero.
- Expired  out  1  sticky expiry flag.
- Load_Err  out  1  high for one cycle after a rejected LOAD.

Behaviour:
- Reset:
  - RST_N low asynchronously forces IDLE.
  - Hours, Mins, Secs, Running, Done, Expired and Load_Err all go to 0.
  - Reset mid-count discards the count; no Done is produced.
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- Request priority, evaluated each cycle: LOAD > START > PAUSE > TICK.
- LOAD, in any state:
  - A load is legal when Load_Hours ≤ HOUR_MAX, Load_Mins ≤ 59 and Load_Secs ≤ 59.
  - Legal load: counters take the load values next cycle, state goes to IDLE, Expired clears.
  - Illegal load: counters and state are unchanged; Load_Err pulses high for the next cycle.
  - A TICK in the same cycle as LOAD is ignored.
- START:
  - From IDLE or PAUSED with a nonzero count: go to RUN.
  - With a count of 00:00:00: ignored; no Done.
  - In RUN or EXPIRED: ignored.
- PAUSE:
  - In RUN: go to PAUSED and hold the count.
  - Otherwise: ignored.
- Decrement (RUN and TICK=1, no higher-priority request):
  - Secs > 0: Secs−1.
  - Secs = 0, Mins > 0: Secs←59, Mins−1.
  - Secs = 0, Mins = 0, Hours > 0: Secs←59, Mins←59, Hours−1.
- Expiry:
  - The decrement that produces 00:00:00 also moves the state to EXPIRED, sets Expired and asserts Done.
  - All three take effect in the same cycle the outputs first read 0:0:0.
  - Done is high for exactly one cycle.
  - Expired holds until a legal LOAD or reset.
- EXPIRED: TICK, START and PAUSE have no effect; the counters hold 0.
- Running = 1 exactly when the state is RUN.
- TICK outside RUN is ignored.
- Latency: one CLK from a qualifying TICK to the updated outputs.
- No wrap-around below zero: the counter never passes 00:00:00.

Test Plan:
1. Reset, then LOAD 0:0:3, START, TICK held high → Secs reads 3,2,1,0 on consecutive cycles; Done and Expired rise with Secs=0; Done lasts 1 cycle; Running falls the same cycle.
2. LOAD 1:0:0, START, one TICK → outputs 0:59:59 next cycle; with HOUR_MAX=23, LOAD 0:60:0 → Load_Err pulses, count unchanged.
3. LOAD 0:0:5, START, 2 TICKs, PAUSE, 4 TICKs, START, 3 TICKs → count reads 3 during the pause, Done fires on the final TICK.
4. Same-cycle LOAD 0:0:9 with START and TICK while running at 0:0:4 → count becomes 0:0:9, state IDLE, no decrement.
5. LOAD 0:0:0, START → stays IDLE, no Done; after an expiry, further START/TICK leave Expired=1 and the count at 0 until a legal LOAD clears it.
6. RST_N low mid-run at 0:30:10, asynchronous to CLK → all outputs 0 immediately, no Done; TICKs after release have no effect until LOAD+START.
